// File: rtl/mux_demux_pkg.sv
// Shared types and constants for the stream mux/demux pair.
// Holds the arbiter FSM states and channel indices.
package mux_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
  localparam int   DW  = 8;

  // Index of the channel that is not ch.
  function automatic logic other_ch(input logic ch);
    return ~ch;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with packet lock.
// Purely combinational; gnt is one-hot or zero.
module rr_arb2
  import mux_demux_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       lock_en,
  input  logic       lock_ch,
  output logic [1:0] gnt
);

  logic w_alt;

  assign w_alt = other_ch(prio);

  // Locked channel wins outright; otherwise prio first, then the other.
  always_comb begin
    gnt = 2'b00;
    if (lock_en) begin
      gnt = (lock_ch == CH1) ? 2'b10 : 2'b01;
    end else if (req[prio]) begin
      gnt = (prio == CH1) ? 2'b10 : 2'b01;
    end else if (req[w_alt]) begin
      gnt = (w_alt == CH1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/stream_mux2_arb.sv
// 2-to-1 stream mux, round-robin between packets.
// Output beats carry their source index on out_sel.
module stream_mux2_arb
  import mux_demux_pkg::*;
#(
  parameter int W = DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in0_data,
  input  logic         in0_last,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_last,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic [W-1:0] out_data,
  output logic         out_sel,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  state_e       r_state;
  state_e       w_state_nxt;
  logic         r_prio;
  logic         w_prio_nxt;

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_sel;
  logic         r_last;

  logic         w_load_en;
  logic         w_lock_en;
  logic         w_lock_ch;
  logic [1:0]   w_gnt;
  logic         w_acc0;
  logic         w_acc1;
  logic         w_acc;
  logic         w_ch;
  logic [W-1:0] w_data;
  logic         w_last;

  assign w_load_en = !r_valid || out_ready;
  assign w_lock_en = (r_state != IDLE);
  assign w_lock_ch = (r_state == LOCK1);

  rr_arb2 u_arb (
    .req     ({in1_valid, in0_valid}),
    .prio    (r_prio),
    .lock_en (w_lock_en),
    .lock_ch (w_lock_ch),
    .gnt     (w_gnt)
  );

  // Readies are forced low while reset is held.
  assign in0_ready = w_gnt[0] && w_load_en && !rst;
  assign in1_ready = w_gnt[1] && w_load_en && !rst;

  assign w_acc0 = in0_valid && in0_ready;
  assign w_acc1 = in1_valid && in1_ready;
  assign w_acc  = w_acc0 || w_acc1;
  assign w_ch   = w_acc1 ? CH1 : CH0;
  assign w_data = w_acc1 ? in1_data : in0_data;
  assign w_last = w_acc1 ? in1_last : in0_last;

  // State and priority registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= CH0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  // Lock on a non-final beat; finishing a packet hands prio over.
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (w_last) begin
            w_prio_nxt = other_ch(w_ch);
          end else begin
            w_state_nxt = (w_ch == CH1) ? LOCK1 : LOCK0;
          end
        end
      end
      LOCK0, LOCK1: begin
        if (w_acc && w_last) begin
          w_state_nxt = IDLE;
          w_prio_nxt  = other_ch(w_ch);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Single output stage; holds while stalled downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= CH0;
      r_last  <= 1'b0;
    end else if (w_load_en) begin
      if (w_acc) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_sel   <= w_ch;
        r_last  <= w_last;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_last  = r_last;

endmodule

// File: tb/tb_stream_mux2_arb.sv
// Self-checking bench for stream_mux2_arb.
// Packet-level model, scoreboard and directed literals.
module tb_stream_mux2_arb;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic         in0_last, in0_valid, in0_ready;
  logic         in1_last, in1_valid, in1_ready;
  logic         out_sel, out_last, out_valid;
  logic         out_ready;

  always #5 clk = ~clk;

  stream_mux2_arb #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Source side: pending beats {last,data}, driven values.
  logic [8:0] q0[$], q1[$];
  bit         sv[2];
  logic [7:0] sd[2];
  bit         sl[2];
  int         pct[2];
  int         gap_cfg[2];
  int         gcnt[2];
  bit         acc[2];
  bit         ordy_rand;

  assign in0_valid = sv[0];
  assign in0_data  = sd[0];
  assign in0_last  = sl[0];
  assign in1_valid = sv[1];
  assign in1_data  = sd[1];
  assign in1_last  = sl[1];

  // Scoreboard: accepted-but-not-delivered beats, and output log.
  logic [8:0] e0[$], e1[$];
  logic [8:0] lg[$];
  int         open_ch;

  // Model: packet owner (-1 none), priority, output register.
  int         owner;
  int         prio;
  bit         m_ov, m_ol, m_os;
  logic [7:0] m_od;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
    end
  endtask

  function automatic int qsize(int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [8:0] qfront(int c);
    return (c == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpop(int c);
    if (c == 0) q0.delete(0);
    else q1.delete(0);
  endfunction

  function automatic void qpush(int c, logic [8:0] b);
    if (c == 0) q0.push_back(b);
    else q1.push_back(b);
  endfunction

  function automatic void model_reset();
    if (m_ov) begin
      if (m_os) void'(e1.pop_back());
      else void'(e0.pop_back());
    end
    m_ov = 0; m_ol = 0; m_os = 0; m_od = '0;
    owner = -1; prio = 0; open_ch = -1;
  endfunction

  // Which channel the spec says may move a beat this cycle.
  function automatic int pick(bit v0, bit v1);
    bit v[2];
    v[0] = v0; v[1] = v1;
    if (owner >= 0) return owner;
    if (v[prio]) return prio;
    if (v[1-prio]) return 1 - prio;
    return -1;
  endfunction

  task automatic drive();
    logic [8:0] b;
    for (int c = 0; c < 2; c++) begin
      if (acc[c]) begin
        qpop(c);
        sv[c] = 0;
        gcnt[c] = gap_cfg[c];
        acc[c] = 0;
      end
      if (!sv[c]) begin
        if (gcnt[c] > 0) gcnt[c]--;
        else if (qsize(c) > 0 && $urandom_range(99) < pct[c]) begin
          b = qfront(c);
          sv[c] = 1; sd[c] = b[7:0]; sl[c] = b[8];
        end
      end
    end
    if (ordy_rand) out_ready = ($urandom_range(99) < 70);
  endtask

  task automatic score();
    logic [8:0] b;
    int sz;
    sz = out_sel ? e1.size() : e0.size();
    chk("sb_nonempty", sz != 0, 1);
    if (sz != 0) begin
      b = out_sel ? e1.pop_front() : e0.pop_front();
      chk("sb_beat", {out_last, out_data}, b);
    end
    if (open_ch >= 0) chk("atomic_sel", out_sel, open_ch[0]);
    open_ch = out_last ? -1 : int'(out_sel);
  endtask

  // One clock: compare at negedge, advance model, drive after posedge.
  task automatic do_cycle();
    int g, c;
    bit ld, r0, r1, v0, v1;
    logic [8:0] b;
    @(negedge clk);
    v0 = in0_valid; v1 = in1_valid;
    ld = !m_ov || out_ready;
    g  = pick(v0, v1);
    r0 = !rst && ld && g == 0;
    r1 = !rst && ld && g == 1;
    chk("in0_ready", in0_ready, r0);
    chk("in1_ready", in1_ready, r1);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_last", out_last, m_ol);
    chk("out_sel", out_sel, m_os);
    if (!rst) begin
      if (m_ov && out_ready) begin
        lg.push_back({out_sel, out_data});
        score();
      end
      acc[0] = v0 && r0;
      acc[1] = v1 && r1;
      if (acc[0] || acc[1]) begin
        c = acc[1] ? 1 : 0;
        b = c ? {in1_last, in1_data} : {in0_last, in0_data};
        if (c == 1) e1.push_back(b);
        else e0.push_back(b);
        m_ov = 1; m_od = b[7:0]; m_ol = b[8]; m_os = c[0];
        if (b[8]) begin
          owner = -1; prio = 1 - c;
        end else begin
          owner = c;
        end
      end else if (ld) begin
        m_ov = 0;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic idle(int n);
    repeat (n) do_cycle();
  endtask

  task automatic wait_log(int n, int budget, string nm);
    int k = 0;
    while (lg.size() < n && k < budget) begin
      do_cycle();
      k++;
    end
    chk({nm, "_timeout"}, lg.size() >= n, 1);
  endtask

  // Asynchronous pulse between edges; outputs must clear at once.
  task automatic pulse_rst();
    #1;
    rst = 1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    model_reset();
    do_cycle();
    rst = 0;
  endtask

  initial begin
    int k, len;
    logic [8:0] b;
    out_ready = 1; ordy_rand = 0;
    pct[0] = 100; pct[1] = 100;
    gap_cfg[0] = 0; gap_cfg[1] = 0;
    gcnt[0] = 0; gcnt[1] = 0;
    acc[0] = 0; acc[1] = 0;
    sv[0] = 0; sv[1] = 0;
    sd[0] = '0; sd[1] = '0;
    sl[0] = 0; sl[1] = 0;
    m_ov = 0;
    model_reset();

    // Reset and round-robin of single-beat packets.
    q0.push_back({1'b1, 8'h11}); q0.push_back({1'b1, 8'h11});
    q1.push_back({1'b1, 8'h22}); q1.push_back({1'b1, 8'h22});
    #1 rst = 1;
    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_in0_ready", in0_ready, 0);
    chk("init_in1_ready", in1_ready, 0);
    drive();
    idle(2);
    rst = 0;
    do_cycle();
    chk("rr_first_valid", out_valid, 1);
    chk("rr_first_data", out_data, 8'h11);
    wait_log(4, 40, "rr");
    chk("rr_0", lg[0], {1'b0, 8'h11});
    chk("rr_1", lg[1], {1'b1, 8'h22});
    chk("rr_2", lg[2], {1'b0, 8'h11});
    chk("rr_3", lg[3], {1'b1, 8'h22});

    // Packet lock: in1 waits behind a 3-beat in0 packet.
    idle(2);
    lg.delete();
    q0.push_back({1'b0, 8'hA0});
    q0.push_back({1'b0, 8'hA1});
    q0.push_back({1'b1, 8'hA2});
    q1.push_back({1'b1, 8'hB0});
    wait_log(4, 40, "lock");
    chk("lock_0", lg[0], {1'b0, 8'hA0});
    chk("lock_1", lg[1], {1'b0, 8'hA1});
    chk("lock_2", lg[2], {1'b0, 8'hA2});
    chk("lock_3", lg[3], {1'b1, 8'hB0});

    // Backpressure: 0x5C holds for 4 stalled cycles.
    idle(2);
    q0.push_back({1'b1, 8'h5C});
    q0.push_back({1'b1, 8'h5D});
    k = 0;
    do begin
      do_cycle();
      k++;
    end while (!(out_valid && out_data == 8'h5C) && k < 30);
    chk("bp_reach", out_valid && out_data == 8'h5C, 1);
    out_ready = 0;
    repeat (4) begin
      do_cycle();
      #1;
      chk("bp_hold_data", out_data, 8'h5C);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in0_ready", in0_ready, 0);
      chk("bp_in1_ready", in1_ready, 0);
    end
    out_ready = 1;
    do_cycle();
    chk("bp_next_data", out_data, 8'h5D);
    chk("bp_next_valid", out_valid, 1);

    // Mid-packet bubble on in1 keeps in0 locked out.
    idle(2);
    lg.delete();
    gap_cfg[1] = 2;
    q1.push_back({1'b0, 8'hC0});
    q1.push_back({1'b1, 8'hC1});
    q0.push_back({1'b1, 8'hD0});
    wait_log(3, 60, "bub");
    chk("bub_0", lg[0], {1'b1, 8'hC0});
    chk("bub_1", lg[1], {1'b1, 8'hC1});
    chk("bub_2", lg[2], {1'b0, 8'hD0});
    gap_cfg[1] = 0;

    // Reset after the first beat of a 3-beat in0 packet.
    idle(4);
    q0.push_back({1'b0, 8'hA0});
    q0.push_back({1'b0, 8'hA1});
    q0.push_back({1'b1, 8'hA2});
    k = 0;
    do begin
      do_cycle();
      k++;
    end while (!(out_valid && out_data == 8'hA0) && k < 30);
    chk("rmp_a0_loaded", out_valid && out_data == 8'hA0, 1);
    q1.push_back({1'b1, 8'hB0});
    lg.delete();
    pulse_rst();
    wait_log(3, 40, "rmp");
    chk("rmp_0", lg[0], {1'b0, 8'hA1});
    chk("rmp_1", lg[1], {1'b0, 8'hA2});
    chk("rmp_2", lg[2], {1'b1, 8'hB0});

    // Randomized traffic with random backpressure and gaps.
    ordy_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        pct[0] = $urandom_range(100, 20);
        pct[1] = $urandom_range(100, 20);
        gap_cfg[0] = $urandom_range(2);
        gap_cfg[1] = $urandom_range(2);
      end
      if (i < 2600) begin
        for (int c = 0; c < 2; c++) begin
          if (qsize(c) < 4) begin
            len = $urandom_range(4, 1);
            for (int j = 0; j < len; j++) begin
              b[7:0] = 8'($urandom);
              b[8] = (j == len - 1);
              qpush(c, b);
            end
          end
        end
      end
      do_cycle();
    end
    pct[0] = 100; pct[1] = 100;
    gap_cfg[0] = 0; gap_cfg[1] = 0;
    k = 0;
    while ((q0.size() + q1.size() + e0.size() + e1.size() != 0 || m_ov)
           && k < 500) begin
      do_cycle();
      k++;
    end
    chk("drain_pending", q0.size() + q1.size() + e0.size() + e1.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux2_arb.md
Name: stream_mux2_arb

Overview:
- 2-to-1 stream multiplexer with valid/ready handshake. It is the merging counterpart of the team's 1-to-2 demux.
- Two source channels (in0, in1) are arbitrated round-robin onto one output channel.
- Each beat is tagged with its source index on out_sel, so a downstream 1-to-2 demux can route it back.
- Packets are atomic: once a channel wins, it holds the output until its last beat.

Parameters:
- W, default 8: data width of every channel.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in0_data  input  W  channel 0 data
- in0_last  input  1  channel 0 end-of-packet marker
- in0_valid  input  1  channel 0 beat present
- in0_ready  output  1  channel 0 beat accepted this cycle
- in1_data  input  W  channel 1 data
- in1_last  input  1  channel 1 end-of-packet marker
- in1_valid  input  1  channel 1 beat present
- in1_ready  output  1  channel 1 beat accepted this cycle
- out_data  output  W  registered output data
- out_sel  output  1  source index of the current output beat (0 or 1)
- out_last  output  1  registered end-of-packet marker
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts the output beat

Behaviour:
- Reset: one clock (clk); reset rst is asynchronous and active-high. While rst=1: out_valid=0, out_data=0, out_sel=0, out_last=0, state=IDLE, priority pointer prio=0. in0_ready and in1_ready are 0 while rst is high.
- Handshake: a transfer occurs on a channel when valid && ready at the rising edge. Once valid is raised, the source holds data/last/valid stable until the transfer.
- Output register: a single stage. load_en = !out_valid || out_ready.
  - On an accepted input beat: out_data, out_last and out_sel load, and out_valid becomes 1.
  - If out_ready=1 and no input beat is accepted, out_valid becomes 0.
  - While out_valid=1 and out_ready=0, all out_* hold stable.
- Latency: 1 cycle from input acceptance to out_valid. Throughput is 1 beat per cycle with out_ready held at 1.
- Ready: inX_ready = grantX && load_en. At most one of in0_ready/in1_ready is high in any cycle.
- States:
  - IDLE: grant goes to the prio channel if it is valid, otherwise to the other channel if valid. With both valid, prio wins.
    - Accepted beat with last=1: stay in IDLE, prio := the other channel.
    - Accepted beat with last=0: go to LOCK0 or LOCK1, matching the winner.
  - LOCKx: grant only channel x. The other channel's valid is ignored, and its ready stays 0.
    - Accepted beat from x with last=1: go to IDLE, prio := the other channel.
    - Otherwise: stay in LOCKx, including cycles where x is not valid (bubbles are allowed mid-packet).
- Single-beat packets (last=1 on the first beat) never enter LOCK.
- Reset mid-packet: return immediately to IDLE with prio=0. The partial packet is discarded and the output register is cleared. No recovery of the truncated packet is attempted.
- No combinational path from inX_valid to out_valid. inX_ready does depend combinationally on out_ready and on the inX_valid inputs (through the IDLE grant).

Decomposition:
- Shared package (mux_demux_pkg) holds:
  - state enum: IDLE, LOCK0, LOCK1;
  - channel index constants: CH0=1'b0, CH1=1'b1;
  - default width constant: DW=8.
- One sub-module: rr_arb2. Inputs: req[1:0], prio, lock_en, lock_ch. Output: one-hot gnt[1:0]. Pure combinational.
- The top level holds the FSM, the prio register and the output register.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with out_valid=1 -> out_valid, out_data, out_sel and out_last go to 0 immediately; both readies are 0 while rst=1.
- Round-robin: in0 and in1 both continuously valid with single-beat packets (in0_data 0x11, in1_data 0x22, last=1), out_ready=1 -> output sequence out_sel 0,1,0,1 with data 0x11,0x22,0x11,0x22; first out_valid one cycle after rst deasserts and inputs are present.
- Packet lock: in0 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with last on 0xA2) while in1 holds valid with 0xB0 -> output is 0xA0, 0xA1, 0xA2 (sel=0), then 0xB0 (sel=1); in1_ready stays 0 during the lock.
- Backpressure: out_ready=0 for 4 cycles while out_valid=1 with data 0x5C -> out_data stays 0x5C and both in ready signals stay 0; out_ready returns to 1 -> the next beat appears the following cycle.
- Mid-packet bubble: in1 sends 0xC0 (last=0), drops valid for 2 cycles, then sends 0xC1 (last=1) while in0 is valid throughout -> FSM stays in LOCK1; output is 0xC0, 0xC1, then in0's beat.
- Reset mid-packet: rst pulses after 0xA0 of a 3-beat in0 packet -> FSM returns to IDLE with prio=0; the next beats are arbitrated as a fresh packet.
